icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: NSETS, default 16, number of direct-mapped lines (power of two, 2..256).
REQ-002 Line size fixed: 4 words (16 bytes); offset = addr[3:2]; index = addr[4+log2(NSETS)-1:4]; tag = remaining upper bits of addr[31:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pcF  input  32  fetch address from the datapath fetch stage; bits [1:0] ignored.
REQ-006 instrF  output  32  instruction word delivered to the fetch/decode register.
REQ-007 stallI  output  1  high = instrF not valid this cycle; ORed into the datapath's fetch/decode stall.
REQ-008 flushI  input  1  single-cycle request to invalidate all lines.
REQ-009 mem_req  output  1  line-fill request to main memory, held high for the entire fill.
REQ-010 mem_addr  output  32  word address of the beat currently requested.
REQ-011 mem_ready  input  1  main memory beat-valid; one word accepted per cycle it is high while mem_req is high.
REQ-012 mem_rdata  input  32  beat data, valid when mem_ready is high.

Function
REQ-013 Storage: per line one valid bit, one tag, four 32-bit data words.
REQ-014 FSM states: IDLE, FILL; no other states.
REQ-015 Hit (combinational, IDLE): valid[index] & tag match -> instrF = data[index][offset], stallI = 0, zero-cycle latency.
REQ-016 Miss in IDLE: stallI = 1, instrF = 32'h0000_0000 (nop), same cycle; next edge latches pcF[31:4] into fill address, clears beat counter, enters FILL.
REQ-017 In FILL: stallI = 1, instrF = 0, mem_req = 1, mem_addr = {fill_addr[31:4], cnt[1:0], 2'b00}.
REQ-018 Each cycle in FILL with mem_ready = 1: mem_rdata written to data[fill_index][cnt], cnt increments mod 4; mem_ready = 0 holds all state.
REQ-019 Beats written strictly in order 0,1,2,3 (critical-word-first not supported).
REQ-020 On edge accepting beat 3: tag written, valid set (unless flush pending, REQ-023), state -> IDLE, mem_req low next cycle.
REQ-021 Re-evaluation after FILL uses current pcF; if pcF now misses, a new fill starts (datapath holds pcF stable under stallI, so normally a hit).
REQ-022 flushI in IDLE: all valid bits cleared at next edge; the lookup in that same cycle still uses pre-flush valid bits.
REQ-023 flushI during FILL: latched as pending; fill completes, filled line NOT marked valid, all valid bits cleared on the beat-3 edge, pending cleared.
REQ-024 Outside FILL, mem_req = 0 and mem_addr = 0.
REQ-025 Data/tag arrays need no reset; only valid bits, state, cnt, fill_addr, pending flag are reset.

Reset
REQ-026 reset high at an edge: state = IDLE, all valid = 0, cnt = 0, pending = 0, fill_addr = 0.
REQ-027 After reset: mem_req = 0, mem_addr = 0; stallI = 1 and instrF = 0 (every lookup misses).
REQ-028 reset during FILL aborts the fill: mem_req low the cycle after the reset edge; partially filled line stays invalid.
REQ-029 reset has priority over flushI, mem_ready and miss detection.

Verification
REQ-030 Cold miss: reset, pcF = 0x0040_0000, mem_ready = 1 every cycle -> mem_addr 0x0040_0000/04/08/0C on 4 consecutive cycles, stallI low on the following cycle, instrF = word 0 delivered.
REQ-031 Hit sweep: after REQ-030 fill, pcF = 0x0040_0004..0C -> stallI = 0, instrF equals beats 1..3, mem_req stays 0.
REQ-032 Conflict: NSETS=16, fill 0x0040_0000 then access 0x0040_0100 (same index, new tag) -> miss, refill; return to 0x0040_0000 -> miss again.
REQ-033 Backpressure: mem_ready toggling 1,0,0,1,1,0,1 -> exactly 4 beats accepted, cnt holds on 0 cycles, mem_addr stable while mem_ready = 0.
REQ-034 Flush: flushI during beat 1 of a fill -> fill completes, next access to same pcF misses; flushI in IDLE after hits -> all subsequent accesses miss.
REQ-035 Reset mid-fill: reset asserted after beat 2 -> mem_req = 0 next cycle, re-access of same pcF performs a full 4-beat fill.

Source files
------------

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side signal bundle for the instruction cache
//
// Purpose: groups the fetch lookup signals and the line-fill memory signals that
// connect to the instruction cache.
// Ports (signals):
//   pcF       32  fetch address from the datapath (bits [1:0] ignored)
//   instrF    32  instruction delivered to the fetch/decode register
//   stallI     1  instrF not valid this cycle
//   flushI     1  single-cycle invalidate-all request
//   mem_req    1  line-fill request, held for the whole fill
//   mem_addr  32  word address of the beat being requested
//   mem_ready  1  memory beat valid
//   mem_rdata 32  memory beat data
// Modports: slave = cache side, master = datapath/memory side.
interface icache_if;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        stallI;
  logic        flushI;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  pcF,
    input  flushI,
    input  mem_ready,
    input  mem_rdata,
    output instrF,
    output stallI,
    output mem_req,
    output mem_addr
  );

  modport master (
    output pcF,
    output flushI,
    output mem_ready,
    output mem_rdata,
    input  instrF,
    input  stallI,
    input  mem_req,
    input  mem_addr
  );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with 4-word in-order line fill
//
// Purpose: zero-latency hit lookup on pcF; on a miss the cache stalls fetch and
// fills the whole 16-byte line from main memory, one word per accepted beat.
// Ports:
//   clk    1  clock, all state changes on the rising edge
//   reset  1  synchronous active-high reset
//   bus       icache_if.slave (pcF, instrF, stallI, flushI, mem_req, mem_addr,
//             mem_ready, mem_rdata)
// Parameter NSETS: number of lines, power of two in 2..256.
module icache #(
  parameter int NSETS = 16
) (
  input  logic     clk,
  input  logic     reset,
  icache_if.slave  bus
);
  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 28 - IDXW;

  typedef enum logic {IDLE, FILL} stateT;

  stateT             state;
  logic [NSETS-1:0]  validBits;
  logic [TAGW-1:0]   tagMem  [NSETS];
  logic [31:0]       dataMem [NSETS][4];
  logic [27:0]       fillAddr;     // line address (addr[31:4]) being filled
  logic [1:0]        cnt;          // next beat to request/accept
  logic              flushPending; // flush seen during a fill, applied at its end

  logic [IDXW-1:0]   lookIdx;
  logic [TAGW-1:0]   lookTag;
  logic [1:0]        lookOff;
  logic              hit;
  logic [IDXW-1:0]   fillIdx;
  logic [TAGW-1:0]   fillTag;
  logic              beatAccept;
  logic              lastBeat;
  logic              unusedPcBits;

  assign lookIdx      = bus.pcF[4+IDXW-1:4];
  assign lookTag      = bus.pcF[31:4+IDXW];
  assign lookOff      = bus.pcF[3:2];
  assign fillIdx      = fillAddr[IDXW-1:0];
  assign fillTag      = fillAddr[27:IDXW];
  assign unusedPcBits = ^bus.pcF[1:0];

  assign beatAccept = (state == FILL) && bus.mem_ready;
  assign lastBeat   = beatAccept && (cnt == 2'd3);

  // Hits are only served in IDLE; during a fill the line being written is not
  // yet trustworthy, so fetch simply stalls.
  assign hit = (state == IDLE) && validBits[lookIdx] && (tagMem[lookIdx] == lookTag);

  always_comb begin
    bus.instrF   = 32'h0000_0000;
    bus.stallI   = 1'b1;
    bus.mem_req  = 1'b0;
    bus.mem_addr = 32'h0000_0000;
    if (hit) begin
      bus.instrF = dataMem[lookIdx][lookOff];
      bus.stallI = 1'b0;
    end
    if (state == FILL) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = {fillAddr, cnt, 2'b00};
    end
  end

  // Control state: the only flops that see reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      validBits    <= '0;
      cnt          <= 2'd0;
      flushPending <= 1'b0;
      fillAddr     <= 28'd0;
    end else begin
      case (state)
        IDLE: begin
          // Lookup this cycle already used the old valid bits; clear afterwards.
          if (bus.flushI) begin
            validBits <= '0;
          end
          if (!hit) begin
            fillAddr <= bus.pcF[31:4];
            cnt      <= 2'd0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (bus.flushI) begin
            flushPending <= 1'b1;
          end
          if (beatAccept) begin
            cnt <= cnt + 2'd1;
          end
          if (lastBeat) begin
            state        <= IDLE;
            flushPending <= 1'b0;
            // A flush that arrived during the fill (or on its last beat) wins
            // over marking the new line valid.
            if (flushPending || bus.flushI) begin
              validBits <= '0;
            end else begin
              validBits[fillIdx] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; a stray write during reset lands in a line
  // whose valid bit is cleared anyway.
  always_ff @(posedge clk) begin
    if (beatAccept) begin
      dataMem[fillIdx][cnt] <= bus.mem_rdata;
    end
    if (lastBeat) begin
      tagMem[fillIdx] <= fillTag;
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;
  logic clk;
  logic reset;
  logic memReady;
  int   assertCount;
  int   failCount;

  icache_if bus ();

  icache #(.NSETS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Main memory: each word encodes its own address so misplaced beats show up.
  assign bus.mem_ready = memReady;
  assign bus.mem_rdata = {bus.mem_addr[15:0], ~bus.mem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  // Runs a lookup of addr until stallI drops; returns accepted beats. Ends at a
  // negedge with the hit visible.
  task automatic doFill(input logic [31:0] addr, output int beats);
    bit done;
    done  = 1'b0;
    beats = 0;
    bus.pcF  = addr;
    memReady = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      sample();
      if (bus.stallI === 1'b0) begin
        done = 1'b1;
      end else begin
        if (bus.mem_req === 1'b1 && memReady) beats++;
        step();
      end
    end
    if (!done) begin
      assertCount++;
      failCount++;
      $display("FAIL fill_timeout addr=%h: stallI still high after 50 cycles, required low", addr);
    end
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    bus.pcF    = 32'h0040_0000;
    bus.flushI = 1'b0;
    memReady   = 1'b0;
    step();
    step();
    sample();
    assertCount++;
    if (bus.stallI !== 1'b1) begin failCount++; $display("FAIL reset_stallI got %b required 1", bus.stallI); end
    assertCount++;
    if (bus.instrF !== 32'h0) begin failCount++; $display("FAIL reset_instrF got %h required 00000000", bus.instrF); end
    assertCount++;
    if (bus.mem_req !== 1'b0) begin failCount++; $display("FAIL reset_mem_req got %b required 0", bus.mem_req); end
    assertCount++;
    if (bus.mem_addr !== 32'h0) begin failCount++; $display("FAIL reset_mem_addr got %h required 00000000", bus.mem_addr); end
    step();
  endtask

  task automatic test_cold_miss;
    logic [31:0] expAddr [4];
    expAddr = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C};
    reset    = 1'b0;
    bus.pcF  = 32'h0040_0000;
    memReady = 1'b1;
    sample();
    assertCount++;
    if (bus.stallI !== 1'b1 || bus.mem_req !== 1'b0) begin
      failCount++;
      $display("FAIL cold_miss_detect stallI=%b mem_req=%b required 1/0", bus.stallI, bus.mem_req);
    end
    step();
    for (int b = 0; b < 4; b++) begin
      sample();
      assertCount++;
      if (bus.mem_addr !== expAddr[b] || bus.mem_req !== 1'b1 || bus.stallI !== 1'b1 || bus.instrF !== 32'h0) begin
        failCount++;
        $display("FAIL cold_beat%0d mem_addr=%h mem_req=%b stallI=%b instrF=%h required %h/1/1/00000000",
                 b, bus.mem_addr, bus.mem_req, bus.stallI, bus.instrF, expAddr[b]);
      end
      step();
    end
    sample();
    assertCount++;
    if (bus.stallI !== 1'b0 || bus.instrF !== 32'h0000_FFFF || bus.mem_req !== 1'b0) begin
      failCount++;
      $display("FAIL cold_deliver stallI=%b instrF=%h mem_req=%b required 0/0000ffff/0",
               bus.stallI, bus.instrF, bus.mem_req);
    end
    step();
  endtask

  task automatic test_hit_sweep;
    logic [31:0] expWord [3];
    expWord = '{32'h0004_FFFB, 32'h0008_FFF7, 32'h000C_FFF3};
    for (int i = 0; i < 3; i++) begin
      bus.pcF = 32'h0040_0004 + 32'(4 * i);
      sample();
      assertCount++;
      if (bus.stallI !== 1'b0 || bus.instrF !== expWord[i] || bus.mem_req !== 1'b0) begin
        failCount++;
        $display("FAIL hit_word%0d stallI=%b instrF=%h mem_req=%b required 0/%h/0",
                 i + 1, bus.stallI, bus.instrF, bus.mem_req, expWord[i]);
      end
      step();
    end
  endtask

  task automatic test_conflict;
    int beats;
    doFill(32'h0040_0100, beats);
    assertCount++;
    if (beats !== 4 || bus.instrF !== 32'h0100_FEFF) begin
      failCount++;
      $display("FAIL conflict_fill beats=%0d instrF=%h required 4/0100feff", beats, bus.instrF);
    end
    step();
    doFill(32'h0040_0000, beats);
    assertCount++;
    if (beats !== 4 || bus.instrF !== 32'h0000_FFFF) begin
      failCount++;
      $display("FAIL conflict_return beats=%0d instrF=%h required 4/0000ffff", beats, bus.instrF);
    end
    step();
  endtask

  task automatic test_backpressure;
    logic pat [7];
    int   expCnt;
    pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    expCnt   = 0;
    bus.pcF  = 32'h0040_0010;
    memReady = 1'b0;
    sample();
    step();
    for (int k = 0; k < 7; k++) begin
      memReady = pat[k];
      sample();
      assertCount++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== (32'h0040_0010 + 32'(4 * expCnt))) begin
        failCount++;
        $display("FAIL bp_cycle%0d mem_req=%b mem_addr=%h required 1/%h",
                 k, bus.mem_req, bus.mem_addr, 32'h0040_0010 + 32'(4 * expCnt));
      end
      if (pat[k]) expCnt++;
      step();
    end
    memReady = 1'b1;
    sample();
    assertCount++;
    if (bus.stallI !== 1'b0 || bus.instrF !== 32'h0010_FFEF || bus.mem_req !== 1'b0) begin
      failCount++;
      $display("FAIL bp_done stallI=%b instrF=%h mem_req=%b required 0/0010ffef/0",
               bus.stallI, bus.instrF, bus.mem_req);
    end
    step();
    bus.pcF = 32'h0040_001C;
    sample();
    assertCount++;
    if (bus.stallI !== 1'b0 || bus.instrF !== 32'h001C_FFE3) begin
      failCount++;
      $display("FAIL bp_word3 stallI=%b instrF=%h required 0/001cffe3", bus.stallI, bus.instrF);
    end
    step();
  endtask

  task automatic test_flush_fill;
    int beats;
    bus.pcF  = 32'h0040_0020;
    memReady = 1'b1;
    sample();
    step();
    sample();
    step();
    bus.flushI = 1'b1;
    sample();
    assertCount++;
    if (bus.mem_addr !== 32'h0040_0024) begin
      failCount++;
      $display("FAIL flushfill_beat1 mem_addr=%h required 00400024", bus.mem_addr);
    end
    step();
    bus.flushI = 1'b0;
    sample();
    step();
    sample();
    step();
    sample();
    assertCount++;
    if (bus.stallI !== 1'b1 || bus.mem_req !== 1'b0) begin
      failCount++;
      $display("FAIL flushfill_not_valid stallI=%b mem_req=%b required 1/0", bus.stallI, bus.mem_req);
    end
    step();
    doFill(32'h0040_0020, beats);
    assertCount++;
    if (beats !== 4 || bus.instrF !== 32'h0020_FFDF) begin
      failCount++;
      $display("FAIL flushfill_refill beats=%0d instrF=%h required 4/0020ffdf", beats, bus.instrF);
    end
    step();
    bus.pcF = 32'h0040_0010;
    sample();
    assertCount++;
    if (bus.stallI !== 1'b1) begin
      failCount++;
      $display("FAIL flushfill_other_line stallI=%b required 1", bus.stallI);
    end
    step();
    doFill(32'h0040_0010, beats);
    step();
  endtask

  task automatic test_flush_idle;
    int beats;
    bus.pcF    = 32'h0040_0020;
    bus.flushI = 1'b1;
    sample();
    assertCount++;
    if (bus.stallI !== 1'b0 || bus.instrF !== 32'h0020_FFDF) begin
      failCount++;
      $display("FAIL flushidle_same_cycle stallI=%b instrF=%h required 0/0020ffdf", bus.stallI, bus.instrF);
    end
    step();
    bus.flushI = 1'b0;
    sample();
    assertCount++;
    if (bus.stallI !== 1'b1) begin
      failCount++;
      $display("FAIL flushidle_after stallI=%b required 1", bus.stallI);
    end
    step();
    doFill(32'h0040_0020, beats);
    assertCount++;
    if (beats !== 4) begin
      failCount++;
      $display("FAIL flushidle_refill beats=%0d required 4", beats);
    end
    step();
    bus.pcF = 32'h0040_0010;
    sample();
    assertCount++;
    if (bus.stallI !== 1'b1) begin
      failCount++;
      $display("FAIL flushidle_other_line stallI=%b required 1", bus.stallI);
    end
    step();
    doFill(32'h0040_0010, beats);
    step();
  endtask

  task automatic test_reset_mid_fill;
    int beats;
    bus.pcF  = 32'h0040_0030;
    memReady = 1'b1;
    sample();
    step();
    for (int b = 0; b < 3; b++) begin
      sample();
      step();
    end
    reset = 1'b1;
    sample();
    assertCount++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0040_003C) begin
      failCount++;
      $display("FAIL rstfill_before mem_req=%b mem_addr=%h required 1/0040003c", bus.mem_req, bus.mem_addr);
    end
    step();
    reset = 1'b0;
    sample();
    assertCount++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.stallI !== 1'b1) begin
      failCount++;
      $display("FAIL rstfill_abort mem_req=%b mem_addr=%h stallI=%b required 0/00000000/1",
               bus.mem_req, bus.mem_addr, bus.stallI);
    end
    step();
    doFill(32'h0040_0030, beats);
    assertCount++;
    if (beats !== 4 || bus.instrF !== 32'h0030_FFCF) begin
      failCount++;
      $display("FAIL rstfill_refill beats=%0d instrF=%h required 4/0030ffcf", beats, bus.instrF);
    end
    step();
    bus.pcF = 32'h0040_0000;
    sample();
    assertCount++;
    if (bus.stallI !== 1'b1) begin
      failCount++;
      $display("FAIL rstfill_all_invalid stallI=%b required 1", bus.stallI);
    end
    step();
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    test_reset();
    test_cold_miss();
    test_hit_sweep();
    test_conflict();
    test_backpressure();
    test_flush_fill();
    test_flush_idle();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
